// File: rtl/puf_pkg.sv
// Shared constants and types for the PUF scan controller.
// Cell count, select width and scan-state encoding.
package puf_pkg;

    localparam int unsigned CELL_NUM = 128;
    localparam int unsigned SEL_W    = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } scan_state_t;

endpackage

// File: rtl/puf_maj_vote.sv
// Majority voter for one PUF cell.
// Counts samples and ones, reports the decision on the last sample.
module puf_maj_vote #(
    parameter int unsigned VOTES = 3
) (
    input  logic i_Clk,
    input  logic i_Rst_n,
    input  logic i_Clr,
    input  logic i_En,
    input  logic i_Bit,
    output logic o_Cnt_done,
    output logic o_Result
);

    localparam logic [2:0] LAST = 3'(VOTES - 1);
    localparam logic [3:0] HALF = 4'(VOTES / 2);

    logic [2:0] n_cnt;
    logic [3:0] ones;
    logic [3:0] ones_nxt;

    assign ones_nxt   = ones + {3'b000, i_Bit};
    assign o_Cnt_done = i_En && (n_cnt == LAST);
    assign o_Result   = ones_nxt > HALF;

    // Sample and ones counters; self-clear after the last vote
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            n_cnt <= '0;
            ones  <= '0;
        end else if (i_Clr) begin
            n_cnt <= '0;
            ones  <= '0;
        end else if (i_En) begin
            if (n_cnt == LAST) begin
                n_cnt <= '0;
                ones  <= '0;
            end else begin
                n_cnt <= n_cnt + 3'd1;
                ones  <= ones_nxt;
            end
        end
    end

endmodule

// File: rtl/puf_scan_ctrl.sv
// PUF array scan controller.
// Walks all cells, settles each, majority-votes its bit.
module puf_scan_ctrl
    import puf_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned VOTES      = 3
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    input  logic                i_Abort,
    input  logic                i_Bit,
    output logic [SEL_W-1:0]    o_Sel,
    output logic                o_En,
    output logic                o_Busy,
    output logic                o_Done,
    output logic                o_Valid,
    output logic [CELL_NUM-1:0] o_Resp
);

    generate
        if (SETTLE_CYC < 2 || SETTLE_CYC > 255) begin : g_bad_settle
            $error("SETTLE_CYC must be 2..255");
        end
        if (VOTES < 1 || VOTES > 7 || (VOTES % 2) == 0) begin : g_bad_votes
            $error("VOTES must be odd, 1..7");
        end
    endgenerate

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(CELL_NUM - 1);

    scan_state_t         state;
    scan_state_t         nxt;
    logic [7:0]          cnt;
    logic [SEL_W-1:0]    idx;
    logic [1:0]          sync;
    logic [CELL_NUM-1:0] resp;
    logic                valid;

    logic accept;
    logic abort;
    logic settle_end;
    logic busy;
    logic last_cell;
    logic vote_en;
    logic vote_clr;
    logic vote_done;
    logic vote_res;

    assign busy      = (state == ST_SETTLE) || (state == ST_SAMPLE);
    assign last_cell = (idx == IDX_LAST);
    assign vote_en   = (state == ST_SAMPLE);
    assign vote_clr  = accept || abort;

    assign o_Sel   = busy ? idx : '0;
    assign o_En    = busy;
    assign o_Busy  = busy;
    assign o_Done  = (state == ST_DONE);
    assign o_Valid = valid;
    assign o_Resp  = resp;

    puf_maj_vote #(
        .VOTES(VOTES)
    ) u_vote (
        .i_Clk      (i_Clk),
        .i_Rst_n    (i_Rst_n),
        .i_Clr      (vote_clr),
        .i_En       (vote_en),
        .i_Bit      (sync[1]),
        .o_Cnt_done (vote_done),
        .o_Result   (vote_res)
    );

    // Next-state and scan control strobes
    always_comb begin
        nxt        = state;
        accept     = 1'b0;
        abort      = 1'b0;
        settle_end = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_Start) begin
                    nxt    = ST_SETTLE;
                    accept = 1'b1;
                end
            end
            ST_SETTLE: begin
                if (i_Abort) begin
                    nxt   = ST_IDLE;
                    abort = 1'b1;
                end else if (cnt == SETTLE_LAST) begin
                    nxt        = ST_SAMPLE;
                    settle_end = 1'b1;
                end
            end
            ST_SAMPLE: begin
                if (i_Abort) begin
                    nxt   = ST_IDLE;
                    abort = 1'b1;
                end else if (vote_done) begin
                    nxt = last_cell ? ST_DONE : ST_SETTLE;
                end
            end
            ST_DONE: nxt = ST_IDLE;
            default: nxt = ST_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) state <= ST_IDLE;
        else          state <= nxt;
    end

    // Two-flop synchronizer for the asynchronous cell bit
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) sync <= 2'b00;
        else          sync <= {sync[0], i_Bit};
    end

    // Settle counter and cell index; index stops at the last cell
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            cnt <= '0;
            idx <= '0;
        end else if (accept || abort) begin
            cnt <= '0;
            idx <= '0;
        end else if (state == ST_SETTLE) begin
            cnt <= settle_end ? 8'd0 : cnt + 8'd1;
        end else if (vote_en && vote_done && !last_cell) begin
            idx <= idx + 1'b1;
        end
    end

    // Response assembly and valid flag
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            resp  <= '0;
            valid <= 1'b0;
        end else if (accept || abort) begin
            resp  <= '0;
            valid <= 1'b0;
        end else if (vote_en && vote_done) begin
            resp[idx] <= vote_res;
            if (last_cell) valid <= 1'b1;
        end
    end

endmodule

// File: tb/tb_puf_scan_ctrl.sv
// Bench for puf_scan_ctrl: full scans, votes, abort, reset.
// Expected responses come from a per-cell majority model.
module tb_puf_scan_ctrl;
    import puf_pkg::*;

    localparam int SC   = 16;
    localparam int V    = 3;
    localparam int P    = SC + V;
    localparam int LAST = CELL_NUM * P;

    logic         i_Clk   = 1'b0;
    logic         i_Rst_n = 1'b0;
    logic         i_Start = 1'b0;
    logic         i_Abort = 1'b0;
    logic         i_Bit   = 1'b0;
    logic [6:0]   o_Sel;
    logic         o_En;
    logic         o_Busy;
    logic         o_Done;
    logic         o_Valid;
    logic [127:0] o_Resp;

    int   checks = 0;
    int   errors = 0;
    logic drv [0:LAST];

    puf_scan_ctrl #(
        .SETTLE_CYC(SC),
        .VOTES     (V)
    ) dut (
        .i_Clk   (i_Clk),
        .i_Rst_n (i_Rst_n),
        .i_Start (i_Start),
        .i_Abort (i_Abort),
        .i_Bit   (i_Bit),
        .o_Sel   (o_Sel),
        .o_En    (o_En),
        .o_Busy  (o_Busy),
        .o_Done  (o_Done),
        .o_Valid (o_Valid),
        .o_Resp  (o_Resp)
    );

    always #5 i_Clk = ~i_Clk;

    task automatic check(input string tag,
                         input logic [127:0] got,
                         input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge i_Clk);
        #1;
    endtask

    function automatic logic gen(int mode, int r);
        int k;
        int c;
        int j;
        case (mode)
            0: return 1'b1;
            1: return o_Sel[0];
            2: return 1'($urandom_range(0, 1));
            default: begin
                k = r - (SC - 1);
                if (k < 0) return 1'b0;
                c = k / P;
                j = k % P;
                if (j >= V) return 1'b0;
                if (c == 5) return j != 1;
                if (c == 6) return j == 1;
                return 1'b0;
            end
        endcase
    endfunction

    function automatic logic [127:0] model();
        logic [127:0] m;
        int ones;
        m = '0;
        for (int c = 0; c < CELL_NUM; c++) begin
            ones = 0;
            for (int j = 0; j < V; j++)
                ones += int'(drv[c*P + SC - 1 + j]);
            m[c] = ones > V / 2;
        end
        return m;
    endfunction

    function automatic logic [127:0] outs();
        return {120'(o_Sel), o_En, o_Busy, o_Done,
                o_Valid, 4'h0} | o_Resp;
    endfunction

    task automatic scan(input int mode, input int ev,
                        input logic both);
        int bad_sel = 0;
        int bad_st  = 0;
        int bad_lo  = 0;
        int dn      = 0;
        int ev_r    = 0;
        bit stop    = 0;
        logic [127:0] exp;
        case (ev)
            1: ev_r = 40 * P + 1;
            2: ev_r = 10 * P + 1;
            3: ev_r = 60 * P + 1;
            4: ev_r = 90 * P + 1;
            default: ev_r = -1;
        endcase
        i_Start = 1'b1;
        i_Abort = both;
        i_Bit   = gen(mode, 0);
        drv[0]  = i_Bit;
        step();
        i_Start = 1'b0;
        i_Abort = 1'b0;
        for (int r = 1; r <= LAST && !stop; r++) begin
            if (o_Sel !== 7'((r - 1) / P)) bad_sel++;
            if (o_En !== 1'b1 || o_Busy !== 1'b1 ||
                o_Done !== 1'b0 || o_Valid !== 1'b0)
                bad_st++;
            if ((o_Resp >> ((r - 1) / P)) != '0) bad_lo++;
            if (r == ev_r && (ev == 1 || ev == 3)) begin
                i_Abort = 1'b1;
                i_Start = (ev == 3);
                step();
                i_Abort = 1'b0;
                i_Start = 1'b0;
                check("abort_busy", o_Busy, 0);
                check("abort_resp", o_Resp, 0);
                check("abort_valid", o_Valid, 0);
                check("abort_sel_en", {o_Sel, o_En}, 0);
                for (int k = 0; k < 2 * P; k++) begin
                    if (o_Done !== 1'b0 || o_Busy !== 1'b0) dn++;
                    step();
                end
                check("abort_quiet", dn, 0);
                stop = 1;
            end else if (r == ev_r && ev == 4) begin
                #2;
                i_Rst_n = 1'b0;
                #1;
                check("rst_async_outs", outs(), 0);
                step();
                step();
                check("rst_hold_outs", outs(), 0);
                i_Rst_n = 1'b1;
                step();
                check("rst_release_idle", outs(), 0);
                stop = 1;
            end else begin
                if (r == ev_r && ev == 2) i_Start = 1'b1;
                i_Bit  = gen(mode, r);
                drv[r] = i_Bit;
                step();
                i_Start = 1'b0;
            end
        end
        if (!stop) begin
            check("scan_sel_seq", bad_sel, 0);
            check("scan_busy_en", bad_st, 0);
            check("scan_unscanned_zero", bad_lo, 0);
            case (mode)
                0:       exp = '1;
                1:       exp = {64{2'b10}};
                3:       exp = 128'h20;
                default: exp = model();
            endcase
            check("done_pulse", o_Done, 1);
            check("done_valid", o_Valid, 1);
            check("done_busy_en", {o_Busy, o_En}, 0);
            check("done_resp", o_Resp, exp);
            step();
            check("post_done", o_Done, 0);
            check("post_valid", o_Valid, 1);
            check("post_resp", o_Resp, exp);
            check("post_idle", {o_Busy, o_En, o_Sel}, 0);
        end
    endtask

    initial begin
        i_Rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            i_Start = 1'($urandom_range(0, 1));
            i_Bit   = 1'($urandom_range(0, 1));
            step();
            check("rst_outs", outs(), 0);
        end
        i_Start = 1'b0;
        i_Bit   = 1'b0;
        i_Rst_n = 1'b1;
        step();
        check("idle_outs", outs(), 0);

        scan(0, 0, 1'b0);
        i_Abort = 1'b1;
        step();
        i_Abort = 1'b0;
        check("idle_abort_valid", o_Valid, 1);
        check("idle_abort_resp", o_Resp, '1);
        check("idle_abort_busy", o_Busy, 0);

        scan(1, 0, 1'b0);
        scan(3, 0, 1'b0);
        scan(2, 0, 1'b1);
        scan(2, 2, 1'b0);
        scan(0, 1, 1'b0);
        scan(2, 0, 1'b0);
        scan(0, 3, 1'b0);
        scan(0, 4, 1'b0);
        scan(2, 0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
